// File: rtl/crc16_tx_pkg.sv
// Shared types and sizing for the CRC16 serial transmit controller.
package crc16_tx_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned CRC_LEN = 16;
    localparam int unsigned CNT_W   = $clog2(CRC_LEN);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BYTE_W - 1);
    localparam logic [CNT_W-1:0] DUMP_LAST = CNT_W'(CRC_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHIFT,
        CRC,
        DONE
    } state_t;

endpackage

// File: rtl/flex_counter.sv
// Up-counter with synchronous clear and a runtime rollover value.
module flex_counter #(
    parameter int unsigned NUM_BITS = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                clear,
    input  logic                count_enable,
    input  logic [NUM_BITS-1:0] rollover_val,
    output logic [NUM_BITS-1:0] count_out,
    output logic                rollover_flag
);

    logic [NUM_BITS-1:0] count_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (count_enable) begin
            if (count_q == rollover_val) begin
                count_q <= '0;
            end else begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign count_out     = count_q;
    assign rollover_flag = (count_q == rollover_val);

endmodule

// File: rtl/crc16_tx_ctrl.sv
// Serialises payload bytes LSB first, steering an external CRC16 register,
// then shifts the 16-bit remainder onto the line.
module crc16_tx_ctrl
    import crc16_tx_pkg::*;
(
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic              bit_strobe,
    input  logic [BYTE_W-1:0] data_in,
    input  logic              data_valid,
    input  logic              data_last,
    output logic              data_ready,
    output logic              serial_out,
    output logic              serial_en,
    output logic              crc_clear,
    output logic              crc_enable,
    output logic              crc_bit_in,
    output logic              crc_dump,
    input  logic              crc_bit_out,
    output logic              busy,
    output logic              done,
    output logic              err_underrun
);

    state_t state, next_state;

    logic [BYTE_W-1:0] buf_data;
    logic              buf_last;
    logic              buf_full;
    logic              last_accepted;
    logic [BYTE_W-1:0] shift_reg;
    logic              cur_last;
    logic              in_clear_q;

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_roll;
    logic              cnt_wrap;
    logic              cnt_clear;
    logic              cnt_en;

    logic              active;
    logic              byte_end;
    logic              accept;
    logic              load;
    logic              shift_step;

    // Bit index and CRC dump index share one counter; only the wrap point changes.
    flex_counter #(
        .NUM_BITS(CNT_W)
    ) u_bit_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (cnt_clear),
        .count_enable (cnt_en),
        .rollover_val (cnt_roll),
        .count_out    (cnt),
        .rollover_flag(cnt_wrap)
    );

    assign active     = (state == SHIFT) || (state == CRC);
    assign cnt_clear  = !active;
    assign cnt_en     = active && bit_strobe;
    assign cnt_roll   = (state == CRC) ? DUMP_LAST : BIT_LAST;
    assign byte_end   = (state == SHIFT) && bit_strobe && cnt_wrap;
    assign accept     = data_valid && data_ready;
    assign load       = ((state == CLEAR) && buf_full) || (byte_end && !cur_last && buf_full);
    assign shift_step = (state == SHIFT) && bit_strobe && !cnt_wrap;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (start) next_state = CLEAR;
            CLEAR: if (buf_full) next_state = SHIFT;
            SHIFT: begin
                if (byte_end) begin
                    if (cur_last) begin
                        next_state = CRC;
                    end else if (!buf_full) begin
                        next_state = IDLE;
                    end
                end
            end
            CRC:   if (bit_strobe && cnt_wrap) next_state = DONE;
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state != IDLE);
        serial_en    = active;
        crc_clear    = (state == CLEAR) && !in_clear_q;
        crc_dump     = (state == CRC);
        crc_enable   = active && bit_strobe;
        serial_out   = 1'b0;
        crc_bit_in   = 1'b0;
        if (state == SHIFT) begin
            serial_out = shift_reg[0];
            crc_bit_in = shift_reg[0];
        end else if (state == CRC) begin
            serial_out = crc_bit_out;
        end
        done         = (state == DONE);
        err_underrun = byte_end && !cur_last && !buf_full;
        data_ready   = busy && !buf_full && !last_accepted;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            buf_data      <= '0;
            buf_last      <= 1'b0;
            buf_full      <= 1'b0;
            last_accepted <= 1'b0;
            shift_reg     <= '0;
            cur_last      <= 1'b0;
            in_clear_q    <= 1'b0;
        end else begin
            in_clear_q <= (state == CLEAR);
            if (state == IDLE) begin
                buf_full      <= 1'b0;
                last_accepted <= 1'b0;
            end else begin
                // Fill after drain so a same-cycle accept is never dropped.
                if (load) begin
                    buf_full <= 1'b0;
                end
                if (accept) begin
                    buf_data <= data_in;
                    buf_last <= data_last;
                    buf_full <= 1'b1;
                    if (data_last) begin
                        last_accepted <= 1'b1;
                    end
                end
            end
            if (load) begin
                shift_reg <= buf_data;
                cur_last  <= buf_last;
            end else if (shift_step) begin
                shift_reg <= {1'b0, shift_reg[BYTE_W-1:1]};
            end
        end
    end

endmodule

// File: tb/tb_crc16_tx_ctrl.sv
// Directed, table-driven bench for crc16_tx_ctrl with hand-computed expectations.
module tb_crc16_tx_ctrl;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       start;
    logic       bit_strobe;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_last;
    logic       data_ready;
    logic       serial_out;
    logic       serial_en;
    logic       crc_clear;
    logic       crc_enable;
    logic       crc_bit_in;
    logic       crc_dump;
    logic       crc_bit_out;
    logic       busy;
    logic       done;
    logic       err_underrun;

    always #5 clk = ~clk;

    crc16_tx_ctrl dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
        .bit_strobe  (bit_strobe),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_last   (data_last),
        .data_ready  (data_ready),
        .serial_out  (serial_out),
        .serial_en   (serial_en),
        .crc_clear   (crc_clear),
        .crc_enable  (crc_enable),
        .crc_bit_in  (crc_bit_in),
        .crc_dump    (crc_dump),
        .crc_bit_out (crc_bit_out),
        .busy        (busy),
        .done        (done),
        .err_underrun(err_underrun)
    );

    logic [9:0] outs;
    assign outs = {data_ready, serial_out, serial_en, crc_clear, crc_enable,
                   crc_bit_in, crc_dump, busy, done, err_underrun};

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        int          n;
        int          period;
        bit          withhold;
        bit          poke;
        logic [31:0] exp_bits;
        int          exp_nbits;
        int          exp_dump;
        int          exp_en;
        int          exp_done;
        int          exp_under;
    } vec_t;

    vec_t        vecs [5];
    logic [7:0]  pkt  [3];
    logic [15:0] crc_pat;
    int          checks = 0;
    int          errors = 0;

    logic [31:0] r_bits;
    int r_nbits, r_dump, r_en, r_done, r_under, r_clear;
    int r_ready_err, r_dump_err, r_if_err, r_hold_err, r_timeout;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_pkt(input int n, input int period, input bit withhold, input bit poke);
        int   sent;
        int   ph;
        int   offer;
        int   nb0;
        int   started;
        bit   fin;
        logic prev_en;
        logic prev_strobe;
        logic prev_out;
        logic prev_dump;
        offer = withhold ? 1 : n;
        sent = 0; ph = 0; fin = 1'b0;
        prev_en = 1'b0; prev_strobe = 1'b1; prev_out = 1'b0; prev_dump = 1'b0;
        r_bits = '0; r_nbits = 0; r_dump = 0; r_en = 0; r_done = 0; r_under = 0;
        r_clear = 0; r_ready_err = 0; r_dump_err = 0; r_if_err = 0; r_hold_err = 0;
        r_timeout = 0;
        start = 1'b1; bit_strobe = (period == 1); data_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 1000 && !fin; cyc++) begin
            if (serial_en) ph++;
            bit_strobe  = (period == 1) ? 1'b1 : (serial_en && (ph % period == 0));
            start       = poke && serial_en && (ph == 3);
            data_valid  = (sent < offer);
            data_in     = pkt[(sent < 3) ? sent : 0];
            data_last   = (sent == n - 1);
            crc_bit_out = crc_pat[r_dump[3:0]];
            nb0 = r_nbits;
            #4;
            if (serial_en && bit_strobe && !crc_dump) begin
                if (r_nbits < 32) r_bits[r_nbits] = serial_out;
                r_nbits++;
            end
            if (crc_dump && serial_out !== crc_bit_out) r_dump_err++;
            if (crc_dump && bit_strobe) r_dump++;
            if (crc_enable !== (bit_strobe & serial_en)) r_if_err++;
            if (serial_en && !crc_dump && crc_bit_in !== serial_out) r_if_err++;
            if (prev_en && serial_en && !prev_strobe && prev_dump == crc_dump && serial_out !== prev_out)
                r_hold_err++;
            started = crc_dump ? n : (serial_en ? nb0 / 8 + 1 : 0);
            if (data_ready && (sent - started) >= 1) r_ready_err++;
            r_en    += int'(serial_en);
            r_done  += int'(done);
            r_under += int'(err_underrun);
            r_clear += int'(crc_clear);
            if (done || err_underrun) fin = 1'b1;
            if (data_valid && data_ready) sent++;
            prev_en = serial_en; prev_strobe = bit_strobe; prev_out = serial_out; prev_dump = crc_dump;
            @(posedge clk); #1;
        end
        if (!fin) r_timeout = 1;
        bit_strobe = 1'b0; data_valid = 1'b0; data_last = 1'b0; start = 1'b0;
    endtask

    initial begin
        crc_pat = 16'hB38E;
        vecs[0] = '{b0:8'hA5, b1:8'h00, b2:8'h00, n:1, period:1, withhold:1'b0, poke:1'b0,
                    exp_bits:32'h0000_00A5, exp_nbits:8,  exp_dump:16, exp_en:24, exp_done:1, exp_under:0};
        vecs[1] = '{b0:8'h01, b1:8'h02, b2:8'h03, n:3, period:1, withhold:1'b0, poke:1'b0,
                    exp_bits:32'h0003_0201, exp_nbits:24, exp_dump:16, exp_en:40, exp_done:1, exp_under:0};
        vecs[2] = '{b0:8'h3C, b1:8'hC3, b2:8'h00, n:2, period:1, withhold:1'b1, poke:1'b0,
                    exp_bits:32'h0000_003C, exp_nbits:8,  exp_dump:0,  exp_en:8,  exp_done:0, exp_under:1};
        vecs[3] = '{b0:8'hFF, b1:8'h00, b2:8'h00, n:1, period:4, withhold:1'b0, poke:1'b1,
                    exp_bits:32'h0000_00FF, exp_nbits:8,  exp_dump:16, exp_en:96, exp_done:1, exp_under:0};
        vecs[4] = '{b0:8'h5A, b1:8'h81, b2:8'h00, n:2, period:2, withhold:1'b0, poke:1'b0,
                    exp_bits:32'h0000_815A, exp_nbits:16, exp_dump:16, exp_en:64, exp_done:1, exp_under:0};

        n_rst = 1'b0; start = 1'b1; bit_strobe = 1'b1; data_valid = 1'b1;
        data_last = 1'b1; data_in = 8'hFF; crc_bit_out = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {22'd0, outs}, 32'd0);
        start = 1'b0; bit_strobe = 1'b0; data_valid = 1'b0; data_last = 1'b0;
        crc_bit_out = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            pkt[0] = vecs[i].b0; pkt[1] = vecs[i].b1; pkt[2] = vecs[i].b2;
            run_pkt(vecs[i].n, vecs[i].period, vecs[i].withhold, vecs[i].poke);
            check($sformatf("v%0d_timeout", i),   r_timeout,   0);
            check($sformatf("v%0d_bits", i),      r_bits,      vecs[i].exp_bits);
            check($sformatf("v%0d_nbits", i),     r_nbits,     vecs[i].exp_nbits);
            check($sformatf("v%0d_dump", i),      r_dump,      vecs[i].exp_dump);
            check($sformatf("v%0d_en_cycles", i), r_en,        vecs[i].exp_en);
            check($sformatf("v%0d_done", i),      r_done,      vecs[i].exp_done);
            check($sformatf("v%0d_underrun", i),  r_under,     vecs[i].exp_under);
            check($sformatf("v%0d_clear", i),     r_clear,     1);
            check($sformatf("v%0d_ready", i),     r_ready_err, 0);
            check($sformatf("v%0d_dump_path", i), r_dump_err,  0);
            check($sformatf("v%0d_crc_if", i),    r_if_err,    0);
            check($sformatf("v%0d_hold", i),      r_hold_err,  0);
            check($sformatf("v%0d_busy_after", i), {31'd0, busy}, 0);
            repeat (2) @(posedge clk);
            #1;
        end

        // Asynchronous reset in the middle of the CRC dump.
        begin
            int k;
            int idle_bad;
            start = 1'b1; bit_strobe = 1'b1; data_valid = 1'b0;
            @(posedge clk); #1;
            start = 1'b0; data_valid = 1'b1; data_in = 8'hC3; data_last = 1'b1;
            k = 0;
            while (!crc_dump && k < 100) begin
                @(posedge clk); #1;
                k++;
            end
            check("rst_reach_crc", {31'd0, crc_dump}, 1);
            repeat (5) @(posedge clk);
            #1;
            data_valid = 1'b0; crc_bit_out = 1'b1;
            #2;
            n_rst = 1'b0;
            #1;
            check("rst_mid_crc_outputs", {22'd0, outs}, 32'd0);
            repeat (2) @(posedge clk);
            @(negedge clk);
            n_rst = 1'b1;
            idle_bad = 0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (busy || done || err_underrun || serial_en) idle_bad++;
            end
            check("rst_recover_idle", idle_bad, 0);
            bit_strobe = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/crc16_tx_ctrl.md
CRC16_TX_CTRL -- requirements
Module: crc16_tx_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-002 SHALL have port n_rst, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, one-cycle packet start request; honored only in IDLE.
REQ-004 SHALL have port bit_strobe, input, 1, one-cycle bit-time enable; one serial bit advances per strobe.
REQ-005 SHALL have port data_in, input, 8, payload byte.
REQ-006 SHALL have port data_valid, input, 1, data_in/data_last valid.
REQ-007 SHALL have port data_last, input, 1, marks final payload byte.
REQ-008 SHALL have port data_ready, output, 1, byte accepted on the cycle data_valid and data_ready are both high.
REQ-009 SHALL have port serial_out, output, 1, current line bit.
REQ-010 SHALL have port serial_en, output, 1, serial_out meaningful.
REQ-011 SHALL have port crc_clear, output, 1, reinitialise external CRC16 register.
REQ-012 SHALL have port crc_enable, output, 1, advance external CRC16 one bit.
REQ-013 SHALL have port crc_bit_in, output, 1, bit presented to CRC16.
REQ-014 SHALL have port crc_dump, output, 1, CRC16 shifting out its remainder.
REQ-015 SHALL have port crc_bit_out, input, 1, CRC16 remainder MSB.
REQ-016 SHALL have ports busy, done and err_underrun, output, 1 each: packet active, one-cycle completion pulse, one-cycle abort pulse.

Function
REQ-017 States SHALL be IDLE, CLEAR, SHIFT, CRC, DONE.
REQ-018 IDLE->CLEAR on start; start SHALL be ignored in every other state.
REQ-019 crc_clear SHALL be 1 for exactly the first cycle in CLEAR.
REQ-020 The holding buffer SHALL be one byte plus last flag; data_ready = busy & ~buf_full & ~last_accepted.
REQ-021 CLEAR->SHIFT on the first cycle buf_full=1; the buffer SHALL move into the shift register and bit_cnt=0; CLEAR SHALL never raise underrun.
REQ-022 In SHIFT, serial_out = shift_reg[0] (LSB first), crc_bit_in = serial_out, crc_enable = bit_strobe.
REQ-023 On each SHIFT strobe with bit_cnt<7, shift_reg SHALL shift right and bit_cnt SHALL increment.
REQ-024 On a SHIFT strobe with bit_cnt=7: current byte last->CRC with dump_cnt=0; else buf_full->reload, bit_cnt=0; else err_underrun=1 that cycle and next state IDLE.
REQ-025 In CRC, crc_dump=1, serial_out = crc_bit_out, crc_enable = bit_strobe; CRC->DONE on the 16th strobe.
REQ-026 DONE SHALL last one cycle with done=1, then IDLE.
REQ-027 serial_en = 1 in SHIFT and CRC only; busy = 1 in any state other than IDLE.
REQ-028 bit_strobe SHALL be ignored outside SHIFT and CRC; between strobes all outputs and counters SHALL hold.
REQ-029 A byte accepted in the same cycle as a reload strobe SHALL be held in the buffer, not lost.

Reset
REQ-030 n_rst low SHALL force IDLE, clear buffer, shift register and counters, and drive every output 0 asynchronously, including mid-packet; no done or err_underrun pulse on recovery.

Structure
REQ-031 Package crc16_tx_pkg SHALL hold the state enum, BYTE_W=8 and CRC_LEN=16.
REQ-032 Bit and dump counting SHALL use one flex_counter sub-module instance (rollover value set from the package).

Verification
REQ-033 Single byte 0xA5, last=1, strobe every cycle -> serial_out 1,0,1,0,0,1,0,1, then 16 cycles with crc_dump=1 and serial_out=crc_bit_out, done on the cycle after the 24th strobe.
REQ-034 Three bytes 0x01,0x02,0x03 held valid -> data_ready low while buf_full; 24 data bits then 16 CRC bits; no underrun.
REQ-035 Two bytes with the second withheld past the 8th strobe -> err_underrun=1 for one cycle, next IDLE, busy=0, no done.
REQ-036 Strobe every 4th cycle, byte 0xFF last -> serial_out and counters stable between strobes; 96 cycles of SHIFT/CRC, then done.
REQ-037 start pulsed during SHIFT -> ignored; n_rst low during CRC -> all outputs 0 immediately; IDLE after release.
